// File: rtl/pipe_pkg.sv
// Shared types and constants for the MIPS pipeline MEM stage.
package pipe_pkg;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    localparam logic [DATA_W-1:0] MEM_ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic {
        IDLE    = 1'b0,
        WAIT_RD = 1'b1
    } mem_state_t;
endpackage

// File: rtl/pipe_mw_reg.sv
// MEM/WB pipeline register; a bubble kills the write enables and holds the data fields.
import pipe_pkg::*;

module pipe_mw_reg (
    input  logic              clock,
    input  logic              resetn,
    input  logic              i_bubble,
    input  logic              i_wreg,
    input  logic              i_m2reg,
    input  logic [DATA_W-1:0] i_alu,
    input  logic [DATA_W-1:0] i_mo,
    input  logic [REG_W-1:0]  i_rn,
    output logic              o_wreg,
    output logic              o_m2reg,
    output logic [DATA_W-1:0] o_alu,
    output logic [DATA_W-1:0] o_mo,
    output logic [REG_W-1:0]  o_rn
);
    logic              r_wreg;
    logic              r_m2reg;
    logic [DATA_W-1:0] r_alu;
    logic [DATA_W-1:0] r_mo;
    logic [REG_W-1:0]  r_rn;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wreg  <= 1'b0;
            r_m2reg <= 1'b0;
            r_alu   <= '0;
            r_mo    <= '0;
            r_rn    <= '0;
        end else if (i_bubble) begin
            r_wreg  <= 1'b0;
            r_m2reg <= 1'b0;
        end else begin
            r_wreg  <= i_wreg;
            r_m2reg <= i_m2reg;
            r_alu   <= i_alu;
            r_mo    <= i_mo;
            r_rn    <= i_rn;
        end
    end

    assign o_wreg  = r_wreg;
    assign o_m2reg = r_m2reg;
    assign o_alu   = r_alu;
    assign o_mo    = r_mo;
    assign o_rn    = r_rn;
endmodule

// File: rtl/pipe_mem_stage.sv
// MIPS MEM stage: data-memory req/gnt/rvalid handshake, pipeline stall and MEM/WB register.
// Optional MEM_TIMEOUT_EN: forced load completion with sticky bus_err after TIMEOUT_CYCLES.
import pipe_pkg::*;

module pipe_mem_stage #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              mwreg,
    input  logic              mm2reg,
    input  logic              mwmem,
    input  logic [DATA_W-1:0] malu,
    input  logic [DATA_W-1:0] mb,
    input  logic [REG_W-1:0]  mrn,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              mem_stall,
    output logic              wwreg,
    output logic              wm2reg,
    output logic [DATA_W-1:0] wmo,
    output logic [DATA_W-1:0] walu,
    output logic [REG_W-1:0]  wrn,
    output logic              bus_err
);
    mem_state_t        r_state;
    mem_state_t        w_next;
    logic              w_mem_op;
    logic              w_ld_done;
    logic              w_timeout;
    logic [DATA_W-1:0] w_mo;

    assign w_mem_op   = mm2reg | mwmem;
    assign dmem_we    = mwmem;
    assign dmem_addr  = malu[ADDR_W-1:0];
    assign dmem_wdata = mb;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        dmem_req  = 1'b0;
        mem_stall = 1'b0;
        w_ld_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_mem_op) begin
                    dmem_req = 1'b1;
                    // a granted store retires now; a granted load waits for rvalid
                    if (!dmem_gnt) begin
                        mem_stall = 1'b1;
                    end else if (!mwmem) begin
                        mem_stall = 1'b1;
                        w_next    = WAIT_RD;
                    end
                end
            end
            WAIT_RD: begin
                if (dmem_rvalid) begin
                    w_ld_done = 1'b1;
                    w_next    = IDLE;
                end else if (w_timeout) begin
                    w_next    = IDLE;
                end else begin
                    mem_stall = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_bus_err;

    assign w_timeout = (r_state == WAIT_RD) && !dmem_rvalid &&
                       (r_cnt == CNT_W'(TIMEOUT_CYCLES));

    // held at zero outside WAIT_RD so every entry starts a fresh count
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_cnt     <= '0;
            r_bus_err <= 1'b0;
        end else begin
            if (r_state != WAIT_RD || dmem_rvalid || w_timeout) r_cnt <= '0;
            else                                                r_cnt <= r_cnt + 1'b1;
            if (w_timeout) r_bus_err <= 1'b1;
        end
    end

    assign bus_err = r_bus_err;
`else
    assign w_timeout = 1'b0;
    assign bus_err   = 1'b0;
`endif

    assign w_mo = w_ld_done ? dmem_rdata :
                  w_timeout ? MEM_ERR_DATA : '0;

    pipe_mw_reg u_mw_reg (
        .clock   (clock),
        .resetn  (resetn),
        .i_bubble(mem_stall),
        .i_wreg  (mwreg),
        .i_m2reg (mm2reg),
        .i_alu   (malu),
        .i_mo    (w_mo),
        .i_rn    (mrn),
        .o_wreg  (wwreg),
        .o_m2reg (wm2reg),
        .o_alu   (walu),
        .o_mo    (wmo),
        .o_rn    (wrn)
    );
endmodule

// File: tb/tb_pipe_mem_stage.sv
// Self-checking bench for pipe_mem_stage: directed scenarios plus randomized transactions
// checked against a transaction-level model of the MEM/WB register contents.
module tb_pipe_mem_stage;
    logic        clock, resetn;
    logic        mwreg, mm2reg, mwmem;
    logic [31:0] malu, mb;
    logic [4:0]  mrn;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        mem_stall, wwreg, wm2reg, bus_err;
    logic [31:0] wmo, walu;
    logic [4:0]  wrn;

    int n_chk = 0;
    int n_fail = 0;

    // model of the last committed MEM/WB data fields
    logic [31:0] exp_alu = 0;
    logic [31:0] exp_mo  = 0;
    logic [4:0]  exp_rn  = 0;

    pipe_mem_stage #(.ADDR_W(32), .TIMEOUT_CYCLES(16)) dut (
        .clock(clock), .resetn(resetn),
        .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
        .malu(malu), .mb(mb), .mrn(mrn),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .mem_stall(mem_stall),
        .wwreg(wwreg), .wm2reg(wm2reg), .wmo(wmo), .walu(walu), .wrn(wrn),
        .bus_err(bus_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Drives one EX/MEM instruction from posedge+1 until it retires into MEM/WB.
    task automatic run_op(input bit ld, input bit st, input bit wr, input logic [31:0] alu,
                          input logic [31:0] b, input logic [4:0] rn, input int gdly,
                          input int rdly, input logic [31:0] rdata, input string nm);
        bit memop  = ld | st;
        bit isload = ld & ~st;
        mwreg = wr; mm2reg = ld; mwmem = st; malu = alu; mb = b; mrn = rn;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        if (memop) begin
            for (int i = 0; i < gdly; i++) begin
                dmem_rvalid = 1'($urandom_range(0, 1));
                dmem_rdata  = $urandom;
                #3;
                n_chk++;
                if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_stall} !== {1'b1, st, alu, b, 1'b1}) begin
                    n_fail++;
                    $display("FAIL %s gnt_wait: req/we/addr/wdata/stall got %b/%b/%h/%h/%b want 1/%b/%h/%h/1",
                             nm, dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_stall, st, alu, b);
                end
                next_cycle();
                n_chk++;
                if ({wwreg, wm2reg, walu, wrn, wmo} !== {2'b00, exp_alu, exp_rn, exp_mo}) begin
                    n_fail++;
                    $display("FAIL %s gnt_bubble: wwreg/wm2reg/walu/wrn/wmo got %b/%b/%h/%0d/%h want 0/0/%h/%0d/%h",
                             nm, wwreg, wm2reg, walu, wrn, wmo, exp_alu, exp_rn, exp_mo);
                end
            end
            dmem_gnt = 1'b1; dmem_rvalid = 1'b0;
            #3;
            n_chk++;
            if ({dmem_req, dmem_we, dmem_addr, mem_stall} !== {1'b1, st, alu, isload}) begin
                n_fail++;
                $display("FAIL %s gnt_cycle: req/we/addr/stall got %b/%b/%h/%b want 1/%b/%h/%b",
                         nm, dmem_req, dmem_we, dmem_addr, mem_stall, st, alu, isload);
            end
            if (isload) begin
                next_cycle();
                dmem_gnt = 1'b0;
                for (int i = 0; i < rdly; i++) begin
                    #3;
                    n_chk++;
                    if ({dmem_req, mem_stall, wwreg} !== 3'b010) begin
                        n_fail++;
                        $display("FAIL %s wait_rd: req/stall/wwreg got %b/%b/%b want 0/1/0",
                                 nm, dmem_req, mem_stall, wwreg);
                    end
                    next_cycle();
                end
                dmem_rvalid = 1'b1; dmem_rdata = rdata;
                #3;
                n_chk++;
                if ({dmem_req, mem_stall} !== 2'b00) begin
                    n_fail++;
                    $display("FAIL %s rvalid_cycle: req/stall got %b/%b want 0/0", nm, dmem_req, mem_stall);
                end
            end
        end else begin
            #3;
            n_chk++;
            if ({dmem_req, mem_stall} !== 2'b00) begin
                n_fail++;
                $display("FAIL %s alu_cycle: req/stall got %b/%b want 0/0", nm, dmem_req, mem_stall);
            end
        end
        next_cycle();
        exp_alu = alu; exp_rn = rn; exp_mo = isload ? rdata : 32'h0;
        n_chk++;
        if ({wwreg, wm2reg, walu, wrn, wmo} !== {wr, ld, exp_alu, exp_rn, exp_mo}) begin
            n_fail++;
            $display("FAIL %s retire: wwreg/wm2reg/walu/wrn/wmo got %b/%b/%h/%0d/%h want %b/%b/%h/%0d/%h",
                     nm, wwreg, wm2reg, walu, wrn, wmo, wr, ld, exp_alu, exp_rn, exp_mo);
        end
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        mwreg = 0; mm2reg = 0; mwmem = 0; malu = 0; mb = 0; mrn = 0;
        dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
        #2;
        n_chk++;
        if ({wwreg, wm2reg, walu, wrn, wmo, bus_err, dmem_req, mem_stall} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: wwreg/wm2reg/walu/wrn/wmo/bus_err/req/stall got %b/%b/%h/%0d/%h/%b/%b/%b want all 0",
                     wwreg, wm2reg, walu, wrn, wmo, bus_err, dmem_req, mem_stall);
        end
        @(negedge clock);
        resetn = 1'b1;
        next_cycle();
        // rvalid in IDLE with no load must not reach wmo
        dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_AAAA;
        #3;
        n_chk++;
        if ({dmem_req, mem_stall} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_rvalid_comb: req/stall got %b/%b want 0/0", dmem_req, mem_stall);
        end
        next_cycle();
        n_chk++;
        if (wmo !== 32'h0) begin
            n_fail++;
            $display("FAIL idle_rvalid_wmo: got %h want 0", wmo);
        end
        dmem_rvalid = 1'b0;
    endtask

    task automatic test_directed();
        run_op(0, 0, 1, 32'd7, 32'h0, 5'd3, 0, 0, 32'h0, "alu_op");
        run_op(0, 1, 0, 32'h40, 32'h1234, 5'd0, 0, 0, 32'h0, "store_gnt0");
        run_op(1, 0, 1, 32'h80, 32'h0, 5'd8, 0, 2, 32'hCAFE_F00D, "load_rv3");
        run_op(0, 1, 0, 32'h44, 32'h9876, 5'd1, 5, 0, 32'h0, "store_gnt5");
        run_op(1, 1, 1, 32'h48, 32'hABCD, 5'd9, 1, 0, 32'h0, "store_wins");
    endtask

    task automatic test_back_to_back();
        run_op(1, 0, 1, 32'h100, 32'h0, 5'd4, 0, 0, 32'h1111_2222, "b2b_ld0");
        run_op(0, 1, 0, 32'h104, 32'h77, 5'd0, 0, 0, 32'h0, "b2b_st");
        run_op(1, 0, 1, 32'h108, 32'h0, 5'd5, 0, 0, 32'h3333_4444, "b2b_ld1");
        run_op(1, 0, 1, 32'h10C, 32'h0, 5'd6, 0, 1, 32'h5555_6666, "b2b_ld2");
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            int k = $urandom_range(0, 3);
            run_op(k == 1 || k == 3, k == 2 || k == 3, 1'($urandom_range(0, 1)), $urandom, $urandom,
                   5'($urandom_range(0, 31)), $urandom_range(0, 4), $urandom_range(0, 4), $urandom, "random");
        end
    endtask

    task automatic test_reset_mid_wait();
        run_op(0, 0, 1, 32'h0BAD_0001, 32'h0, 5'd17, 0, 0, 32'h0, "pre_rst");
        mwreg = 1; mm2reg = 1; mwmem = 0; malu = 32'h200; mrn = 5'd12; dmem_gnt = 1;
        next_cycle();
        dmem_gnt = 0;
        next_cycle();
        #2;
        resetn = 1'b0;
        mwreg = 0; mm2reg = 0; malu = 0; mrn = 0;
        #1;
        n_chk++;
        if ({wwreg, wm2reg, walu, wrn, wmo, mem_stall, dmem_req} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_wait: wwreg/wm2reg/walu/wrn/wmo/stall/req got %b/%b/%h/%0d/%h/%b/%b want all 0",
                     wwreg, wm2reg, walu, wrn, wmo, mem_stall, dmem_req);
        end
        #1;
        resetn = 1'b1;
        dmem_rvalid = 1'b1; dmem_rdata = 32'hFEED_FACE;
        next_cycle();
        exp_alu = 0; exp_rn = 0; exp_mo = 0;
        n_chk++;
        if ({wmo, wm2reg, mem_stall} !== {32'h0, 2'b00}) begin
            n_fail++;
            $display("FAIL late_rvalid: wmo/wm2reg/stall got %h/%b/%b want 0/0/0", wmo, wm2reg, mem_stall);
        end
        dmem_rvalid = 1'b0;
    endtask

    task automatic test_timeout();
`ifdef MEM_TIMEOUT_EN
        int stall_cycles = 0;
        bit done = 0;
        mwreg = 1; mm2reg = 1; mwmem = 0; malu = 32'h300; mrn = 5'd2; dmem_gnt = 1;
        next_cycle();
        dmem_gnt = 0;
        for (int i = 0; i < 64 && !done; i++) begin
            #3;
            if (mem_stall) stall_cycles++;
            else done = 1;
            next_cycle();
        end
        n_chk++;
        if (!done || stall_cycles !== 16) begin
            n_fail++;
            $display("FAIL timeout_len: stall cycles in WAIT_RD got %0d (done=%b) want 16", stall_cycles, done);
        end
        n_chk++;
        if ({wmo, bus_err, wwreg} !== {32'hDEAD_BEEF, 2'b11}) begin
            n_fail++;
            $display("FAIL timeout_data: wmo/bus_err/wwreg got %h/%b/%b want deadbeef/1/1", wmo, bus_err, wwreg);
        end
        exp_alu = 32'h300; exp_rn = 5'd2; exp_mo = 32'hDEAD_BEEF;
        run_op(0, 0, 1, 32'h1, 32'h0, 5'd1, 0, 0, 32'h0, "post_timeout");
        n_chk++;
        if (bus_err !== 1'b1) begin
            n_fail++;
            $display("FAIL bus_err_sticky: got %b want 1", bus_err);
        end
`else
        run_op(1, 0, 1, 32'h300, 32'h0, 5'd2, 0, 20, 32'h1357_9BDF, "long_wait");
        n_chk++;
        if (bus_err !== 1'b0) begin
            n_fail++;
            $display("FAIL bus_err_tied: got %b want 0", bus_err);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid_wait();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
